// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the serial sequence generators and detectors.
//   - seq_state_e : generator FSM states (IDLE/SEND/GAP/DONE)
//   - PAT_W_DEFAULT / PAT_1100 : default pattern length and pattern
//   - CNT_W_DEFAULT : default width of the repeat and gap counters
//   - seq_out_t : bundle of the generator's registered-decode outputs
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int PAT_W_DEFAULT = 4;
  localparam logic [PAT_W_DEFAULT-1:0] PAT_1100 = 4'b1100;

  localparam int CNT_W_DEFAULT = 8;

  // Output bundle, packed so the whole set can be defaulted in one assignment.
  typedef struct packed {
    logic x;
    logic x_valid;
    logic mark;
    logic busy;
    logic done;
  } seq_out_t;

endpackage

// File: rtl/seq_gen_if.sv
// -----------------------------------------------------------------------------
// seq_gen_if
//   Control and serial-output bundle of the pattern generator.
//   Control (master -> slave):
//     start       request, sampled only while the generator is idle
//     abort       cancel the running transfer
//     repeat_cnt  number of pattern repetitions, latched with start
//     gap_len     idle cycles between repetitions, latched with start
//   Stream / status (slave -> master):
//     x, x_valid  serial bit and its qualifier
//     mark        last bit of a repetition
//     busy        transfer in progress
//     done        one-cycle completion pulse
// -----------------------------------------------------------------------------
interface seq_gen_if
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] repeat_cnt;
  logic [CNT_W-1:0] gap_len;

  logic             x;
  logic             x_valid;
  logic             mark;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, repeat_cnt, gap_len,
    input  x, x_valid, mark, busy, done
  );

  modport slave (
    input  start, abort, repeat_cnt, gap_len,
    output x, x_valid, mark, busy, done
  );

endinterface

// File: rtl/seq_down_cnt.sv
// -----------------------------------------------------------------------------
// seq_down_cnt
//   Loadable down counter with a zero flag. It saturates at zero instead of
//   wrapping, so a stray decrement can never produce a huge count.
//   Ports:
//     clk       rising-edge clock
//     reset     synchronous active-low reset (count -> 0)
//     clear     synchronous clear, highest priority after reset
//     load      load load_val
//     load_val  value to load
//     dec       decrement by one (ignored at zero)
//     zero      count == 0
// -----------------------------------------------------------------------------
module seq_down_cnt
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; reset is tested inside the clocked block, making it
  // synchronous.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen
//   Serial pattern transmitter. On start it sends PATTERN MSB-first,
//   repeat_cnt times, with gap_len idle cycles between repetitions, one bit
//   per clock. mark flags bit 0 of every repetition; done pulses once after
//   the last bit. All outputs are decoded from registered state only.
//   Parameters:
//     PAT_W    pattern length in bits (>= 2)
//     PATTERN  pattern, sent MSB first
//     CNT_W    width of the repeat and gap counters
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous active-low reset
//     bus      seq_gen_if.slave (start/abort/repeat_cnt/gap_len in,
//              x/x_valid/mark/busy/done out)
// -----------------------------------------------------------------------------
module seq_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1100,
  parameter int               CNT_W   = CNT_W_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  seq_gen_if.slave bus
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] g_len_q, g_len_d;   // latched gap length

  // Counter controls produced by the next-state logic.
  logic             cnt_clear;
  logic             rep_load, rep_dec, rep_last;
  logic             gap_load, gap_dec, gap_end;
  logic [CNT_W-1:0] rep_load_val, gap_load_val;

  seq_out_t         out_c;

  // The repeat counter holds the repetitions still to come after the current
  // one, so it is loaded with R-1 and "last repetition" is simply its zero
  // flag. Likewise the gap counter is loaded with G-1 and the gap ends on the
  // cycle it reads zero, giving exactly G gap cycles.
  assign rep_load_val = bus.repeat_cnt - CNT_W'(1);
  assign gap_load_val = g_len_q - CNT_W'(1);

  seq_down_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .load     (rep_load),
    .load_val (rep_load_val),
    .dec      (rep_dec),
    .zero     (rep_last)
  );

  seq_down_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .zero     (gap_end)
  );

  // State register (state, bit index, latched gap length).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_LAST;
      g_len_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      g_len_q <= g_len_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    g_len_d   = g_len_q;
    cnt_clear = 1'b0;
    rep_load  = 1'b0;
    rep_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        idx_d = IDX_LAST;
        if (bus.start) begin
          if (bus.repeat_cnt != '0) begin
            rep_load = 1'b1;
            g_len_d  = bus.gap_len;
            state_d  = ST_SEND;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end

      ST_SEND: begin
        if (bus.abort) begin
          // Abort beats everything, including the final bit.
          cnt_clear = 1'b1;
          g_len_d   = '0;
          idx_d     = IDX_LAST;
          state_d   = ST_IDLE;
        end else if (idx_q == '0) begin
          idx_d = IDX_LAST;
          if (rep_last) begin
            state_d = ST_DONE;
          end else begin
            rep_dec = 1'b1;
            if (g_len_q != '0) begin
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          cnt_clear = 1'b1;
          g_len_d   = '0;
          idx_d     = IDX_LAST;
          state_d   = ST_IDLE;
        end else if (gap_end) begin
          idx_d   = IDX_LAST;
          state_d = ST_SEND;
        end else begin
          gap_dec = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: depends on registered state only.
  always_comb begin
    out_c = '0;
    unique case (state_q)
      ST_SEND: begin
        out_c.x       = PATTERN[idx_q];
        out_c.x_valid = 1'b1;
        out_c.mark    = (idx_q == '0);
        out_c.busy    = 1'b1;
      end
      ST_GAP:  out_c.busy = 1'b1;
      ST_DONE: out_c.done = 1'b1;
      default: out_c = '0;
    endcase
  end

  assign bus.x       = out_c.x;
  assign bus.x_valid = out_c.x_valid;
  assign bus.mark    = out_c.mark;
  assign bus.busy    = out_c.busy;
  assign bus.done    = out_c.done;

endmodule
